nco_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer that drives the phase-increment and clock-enable inputs of the NCO core. It steps phi_inc from a start value to a stop value in fixed increments. At each step it waits out the NCO pipeline latency, then holds the tone for a programmed dwell time. It sits between the register/control logic and the NCO, and supports single-shot, repeating-sawtooth and triangle sweeps.

---
 rtl/nco_sweep_ctrl_if.sv | 34 +++
 rtl/nco_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between the register block (master) and the NCO sweep
// sequencer (slave).
interface nco_sweep_ctrl_if #(
  parameter int APR = 32,
  parameter int DWW = 16
);
  logic           start;
  logic           abort;
  logic [APR-1:0] cfg_f_start;
  logic [APR-1:0] cfg_f_stop;
  logic [APR-1:0] cfg_f_step;
  logic [DWW-1:0] cfg_dwell;
  logic [1:0]     cfg_mode;
  logic           free_run;
  logic [APR-1:0] phi_inc_o;
  logic           nco_clken;
  logic           busy;
  logic           tone_valid;
  logic           done;
  logic           aborted;
  logic [15:0]    step_cnt;

  modport master (
    output start, abort, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell,
           cfg_mode, free_run,
    input  phi_inc_o, nco_clken, busy, tone_valid, done, aborted, step_cnt
  );

  modport slave (
    input  start, abort, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell,
           cfg_mode, free_run,
    output phi_inc_o, nco_clken, busy, tone_valid, done, aborted, step_cnt
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the NCO phase increment between two limits,
// waiting out the NCO latency and then dwelling on each tone.
module nco_sweep_ctrl #(
  parameter int APR  = 32,
  parameter int DWW  = 16,
  parameter int NLAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  nco_sweep_ctrl_if.slave  bus
);

  localparam int SW = (NLAT > 1) ? $clog2(NLAT) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(NLAT - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, DWELL, STEP, DONE} state_t;

  state_t         state;
  logic [SW-1:0]  settle_cnt;
  logic [DWW-1:0] dwell_cnt;
  logic [APR-1:0] sh_start;
  logic [APR-1:0] sh_stop;
  logic [APR-1:0] sh_step;
  logic [DWW-1:0] sh_dwell_m1;
  logic [1:0]     sh_mode;
  logic           sh_degen;
  logic           dir_down;
  logic [APR-1:0] phi_inc;
  logic           busy_r;
  logic           tone_valid_r;
  logic           done_r;
  logic           aborted_r;
  logic [15:0]    step_cnt_r;

  // One extra bit so neither the increment nor the decrement can wrap.
  logic [APR:0]   sum_up;
  logic [APR:0]   diff_dn;
  logic [APR-1:0] next_up;
  logic [APR-1:0] next_dn;

  assign sum_up  = {1'b0, phi_inc} + {1'b0, sh_step};
  assign diff_dn = {1'b0, phi_inc} - {1'b0, sh_step};
  assign next_up = (sum_up > {1'b0, sh_stop}) ? sh_stop : sum_up[APR-1:0];
  assign next_dn = (diff_dn[APR] || (diff_dn[APR-1:0] < sh_start)) ?
                   sh_start : diff_dn[APR-1:0];

  assign bus.phi_inc_o  = phi_inc;
  assign bus.nco_clken  = busy_r | bus.free_run;
  assign bus.busy       = busy_r;
  assign bus.tone_valid = tone_valid_r;
  assign bus.done       = done_r;
  assign bus.aborted    = aborted_r;
  assign bus.step_cnt   = step_cnt_r;

  // Sequencer; abort wins over every event except the final DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      dwell_cnt    <= '0;
      sh_start     <= '0;
      sh_stop      <= '0;
      sh_step      <= '0;
      sh_dwell_m1  <= '0;
      sh_mode      <= 2'd0;
      sh_degen     <= 1'b0;
      dir_down     <= 1'b0;
      phi_inc      <= '0;
      busy_r       <= 1'b0;
      tone_valid_r <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      step_cnt_r   <= '0;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      if (bus.abort && (state == SETTLE || state == DWELL || state == STEP)) begin
        state        <= IDLE;
        busy_r       <= 1'b0;
        tone_valid_r <= 1'b0;
        aborted_r    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              sh_start    <= bus.cfg_f_start;
              sh_stop     <= bus.cfg_f_stop;
              sh_step     <= bus.cfg_f_step;
              sh_dwell_m1 <= (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - DWW'(1);
              sh_mode     <= (bus.cfg_mode == 2'd3) ? 2'd0 : bus.cfg_mode;
              sh_degen    <= (bus.cfg_f_stop <= bus.cfg_f_start) ||
                             (bus.cfg_f_step == '0);
              dir_down    <= 1'b0;
              phi_inc     <= bus.cfg_f_start;
              step_cnt_r  <= '0;
              settle_cnt  <= SETTLE_LOAD;
              busy_r      <= 1'b1;
              state       <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              dwell_cnt    <= sh_dwell_m1;
              tone_valid_r <= 1'b1;
              state        <= DWELL;
            end else begin
              settle_cnt <= settle_cnt - SW'(1);
            end
          end
          DWELL: begin
            if (dwell_cnt == '0) begin
              step_cnt_r   <= step_cnt_r + 16'd1;
              tone_valid_r <= 1'b0;
              state        <= STEP;
            end else begin
              dwell_cnt <= dwell_cnt - DWW'(1);
            end
          end
          STEP: begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
            // Degenerate sweeps never leave f_start.
            if (sh_degen) begin
              phi_inc <= sh_start;
              if (sh_mode == 2'd0) begin
                done_r <= 1'b1;
                state  <= DONE;
              end
            end else if (!dir_down) begin
              if (phi_inc == sh_stop) begin
                case (sh_mode)
                  2'd1: phi_inc <= sh_start;
                  2'd2: begin
                    dir_down <= 1'b1;
                    phi_inc  <= next_dn;
                  end
                  default: begin
                    done_r <= 1'b1;
                    state  <= DONE;
                  end
                endcase
              end else begin
                phi_inc <= next_up;
              end
            end else begin
              if (phi_inc == sh_start) begin
                dir_down <= 1'b0;
                phi_inc  <= next_up;
              end else begin
                phi_inc <= next_dn;
              end
            end
          end
          DONE: begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: expected tones are queued when a sweep
// is launched and compared as each dwell begins.
module tb_nco_sweep_ctrl;

  localparam int APR   = 32;
  localparam int DWW   = 16;
  localparam int NLAT  = 10;
  localparam int LIMIT = 2000;

  logic clk;
  logic reset;

  nco_sweep_ctrl_if #(.APR(APR), .DWW(DWW)) bus ();

  nco_sweep_ctrl #(.APR(APR), .DWW(DWW), .NLAT(NLAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int done_cnt      = 0;
  int aborted_cnt   = 0;
  int exp_dwell     = 1;
  int low_run       = 0;
  int dwell_run     = 0;
  bit first_step    = 1'b1;
  bit prev_tv       = 1'b0;
  logic [APR-1:0] exp_phi_q[$];

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] expv);
    checks_total++;
    if (obs === expv) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, obs, expv, $time);
  endtask

  // Monitor: settle/dwell lengths and scoreboard compare at each dwell start.
  always @(negedge clk) begin
    if (reset) begin
      low_run    = 0;
      dwell_run  = 0;
      first_step = 1'b1;
      prev_tv    = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.aborted) aborted_cnt++;
      if (bus.tone_valid && !prev_tv) begin
        check_output("settle_len", 64'(low_run), 64'(first_step ? NLAT : NLAT + 1));
        check_output("clken_busy", 64'(bus.nco_clken), 64'd1);
        check_output("sb_nonempty", 64'(exp_phi_q.size() != 0), 64'd1);
        if (exp_phi_q.size() != 0)
          check_output("phi_inc", 64'(bus.phi_inc_o), 64'(exp_phi_q.pop_front()));
        first_step = 1'b0;
        low_run    = 0;
      end
      if (!bus.tone_valid && prev_tv && bus.busy)
        check_output("dwell_len", 64'(dwell_run), 64'(exp_dwell));
      if (!bus.busy) begin
        low_run    = 0;
        first_step = 1'b1;
      end else if (!bus.tone_valid) begin
        low_run++;
      end
      if (bus.tone_valid) dwell_run++;
      else dwell_run = 0;
      prev_tv = bus.tone_valid;
    end
  end

  task automatic apply_stimulus(input logic [APR-1:0] fs, input logic [APR-1:0] fe,
                                input logic [APR-1:0] st, input logic [DWW-1:0] dw,
                                input logic [1:0] md);
    bus.cfg_f_start = fs;
    bus.cfg_f_stop  = fe;
    bus.cfg_f_step  = st;
    bus.cfg_dwell   = dw;
    bus.cfg_mode    = md;
    exp_dwell       = (dw == '0) ? 1 : int'(dw);
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_seq(input int vals[$]);
    foreach (vals[i]) exp_phi_q.push_back(APR'(vals[i]));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(tag, 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_sb_empty(input string tag);
    int n = 0;
    while (exp_phi_q.size() != 0 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(tag, 64'(exp_phi_q.size()), 64'd0);
  endtask

  // Pulses abort for one cycle and checks the one-cycle teardown response.
  task automatic do_abort(input string tag, input logic [APR-1:0] hold_phi);
    int d0;
    d0 = done_cnt;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_output({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_output({tag, "_tv"}, 64'(bus.tone_valid), 64'd0);
    check_output({tag, "_aborted"}, 64'(bus.aborted), 64'd1);
    check_output({tag, "_phi"}, 64'(bus.phi_inc_o), 64'(hold_phi));
    @(posedge clk); #1;
    check_output({tag, "_pulse"}, 64'(bus.aborted), 64'd0);
    check_output({tag, "_nodone"}, 64'(done_cnt), 64'(d0));
  endtask

  initial begin
    int d0;
    int a0;
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.free_run = 1'b0;
    bus.cfg_f_start = '0; bus.cfg_f_stop = '0; bus.cfg_f_step = '0;
    bus.cfg_dwell = '0; bus.cfg_mode = 2'd0;
    #2;
    check_output("rst_phi", 64'(bus.phi_inc_o), 64'd0);
    check_output("rst_busy", 64'(bus.busy), 64'd0);
    check_output("rst_tv", 64'(bus.tone_valid), 64'd0);
    check_output("rst_done", 64'(bus.done), 64'd0);
    check_output("rst_aborted", 64'(bus.aborted), 64'd0);
    check_output("rst_step_cnt", 64'(bus.step_cnt), 64'd0);
    check_output("rst_clken", 64'(bus.nco_clken), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single up-sweep");
    push_seq('{100, 110, 120, 130});
    apply_stimulus(100, 130, 10, 4, 2'd0);
    check_output("s1_busy", 64'(bus.busy), 64'd1);
    wait_idle("s1_idle");
    check_output("s1_done", 64'(done_cnt), 64'd1);
    check_output("s1_steps", 64'(bus.step_cnt), 64'd4);
    check_output("s1_phi_hold", 64'(bus.phi_inc_o), 64'd130);
    check_output("s1_sb", 64'(exp_phi_q.size()), 64'd0);

    $display("[TB] clamp at f_stop");
    d0 = done_cnt;
    push_seq('{0, 10, 20, 25});
    apply_stimulus(0, 25, 10, 1, 2'd0);
    wait_idle("s2_idle");
    check_output("s2_done", 64'(done_cnt - d0), 64'd1);
    check_output("s2_steps", 64'(bus.step_cnt), 64'd4);
    check_output("s2_sb", 64'(exp_phi_q.size()), 64'd0);

    $display("[TB] triangle");
    push_seq('{0, 10, 20, 10, 0, 10});
    apply_stimulus(0, 20, 10, 4, 2'd2);
    wait_sb_empty("s3_sb");
    do_abort("s3_abort", 10);

    $display("[TB] repeat sawtooth");
    push_seq('{0, 10, 0, 10});
    apply_stimulus(0, 10, 10, 2, 2'd1);
    wait_sb_empty("s3b_sb");
    do_abort("s3b_abort", 10);

    $display("[TB] abort in second dwell");
    push_seq('{100, 110});
    apply_stimulus(100, 130, 10, 4, 2'd0);
    wait_sb_empty("s4_sb");
    do_abort("s4_abort", 110);
    repeat (30) @(posedge clk);
    #1;
    check_output("s4_still_idle", 64'(bus.busy), 64'd0);

    $display("[TB] start while busy, cfg frozen");
    d0 = done_cnt;
    push_seq('{100, 110, 120, 130});
    apply_stimulus(100, 130, 10, 4, 2'd0);
    repeat (15) @(posedge clk);
    #1;
    bus.cfg_f_start = 500; bus.cfg_f_stop = 600; bus.cfg_f_step = 50;
    bus.cfg_mode = 2'd1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("s5a_idle");
    check_output("s5a_done", 64'(done_cnt - d0), 64'd1);
    check_output("s5a_steps", 64'(bus.step_cnt), 64'd4);

    $display("[TB] start and abort together in idle");
    a0 = aborted_cnt;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check_output("s5b_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("s5b_busy_later", 64'(bus.busy), 64'd0);
    check_output("s5b_no_abort", 64'(aborted_cnt), 64'(a0));

    $display("[TB] dwell of zero");
    d0 = done_cnt;
    push_seq('{200, 220});
    apply_stimulus(200, 220, 20, 0, 2'd0);
    wait_idle("s5c_idle");
    check_output("s5c_done", 64'(done_cnt - d0), 64'd1);
    check_output("s5c_steps", 64'(bus.step_cnt), 64'd2);

    $display("[TB] zero step, single mode");
    d0 = done_cnt;
    push_seq('{300});
    apply_stimulus(300, 400, 0, 2, 2'd0);
    wait_idle("s5d_idle");
    check_output("s5d_done", 64'(done_cnt - d0), 64'd1);
    check_output("s5d_steps", 64'(bus.step_cnt), 64'd1);
    check_output("s5d_phi", 64'(bus.phi_inc_o), 64'd300);

    $display("[TB] reversed limits, repeat mode and reserved mode");
    push_seq('{50, 50, 50});
    apply_stimulus(50, 40, 5, 2, 2'd1);
    wait_sb_empty("s5e_sb");
    do_abort("s5e_abort", 50);
    d0 = done_cnt;
    push_seq('{7, 9});
    apply_stimulus(7, 9, 5, 1, 2'd3);
    wait_idle("s5f_idle");
    check_output("s5f_done", 64'(done_cnt - d0), 64'd1);

    $display("[TB] reset mid-settle and free run");
    apply_stimulus(100, 130, 10, 4, 2'd0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("s6_busy", 64'(bus.busy), 64'd0);
    check_output("s6_phi", 64'(bus.phi_inc_o), 64'd0);
    check_output("s6_steps", 64'(bus.step_cnt), 64'd0);
    check_output("s6_tv", 64'(bus.tone_valid), 64'd0);
    check_output("s6_clken", 64'(bus.nco_clken), 64'd0);
    bus.free_run = 1'b1;
    #1;
    check_output("s6_free_run", 64'(bus.nco_clken), 64'd1);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("s6_idle_busy", 64'(bus.busy), 64'd0);
    check_output("s6_idle_clken", 64'(bus.nco_clken), 64'd1);
    check_output("s6_no_done", 64'(bus.done), 64'd0);
    bus.free_run = 1'b0;
    #1;
    check_output("s6_clken_off", 64'(bus.nco_clken), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
